gps_uart_rx: RTL
================

Name: gps_uart_rx

Overview:
- UART receiver for the GPS serial link. It converts the asynchronous rxd line into byte strobes: dataByte plus a 1-cycle dataReady.
- Sits directly upstream of the NMEA sentence parser, which consumes dataByte/dataReady with no backpressure.
- Frame format: 8N1, LSB first.
- Provides a double-flop synchronizer, 3-sample majority voting, start-glitch rejection, framing-error reporting and line-idle hunting after reset or a break.

Parameters:
- SYSCLK_FREQ, 100_000_000, sclk frequency in Hz.
- BAUD_RATE, 9600, serial bit rate in baud.
- CLKS_PER_BIT (localparam), SYSCLK_FREQ/BAUD_RATE (integer divide). Instantiations with a result below 16 are illegal. The bit counter is $clog2(CLKS_PER_BIT) bits wide.

Ports:
- sclk  input  1  system clock; all logic is on its rising edge.
- rstn  input  1  reset, asynchronous assert, active-low. One clock domain only.
- rxd  input  1  raw serial line from the GPS module; asynchronous to sclk; idles high.
- dataByte  output  8  last correctly framed byte; held until the next good byte.
- dataReady  output  1  1-cycle pulse; dataByte is valid in the same cycle.
- frameErr  output  1  1-cycle pulse when a stop bit samples low.

Behaviour:

Reset (rstn low, asynchronous):
- dataByte=0x00, dataReady=0, frameErr=0.
- Synchronizer flops=1, vote history=3'b111, counters=0.
- State=HUNT.
- Reset mid-frame abandons the frame; no partial byte is ever emitted.

Input conditioning:
- rxd passes through 2 flops to give rx_s.
- A 3-bit shift history of rx_s feeds the majority vote; bit value = majority of the 3 most recent rx_s.

State machine:
- HUNT: count consecutive cycles with rx_s=1; any 0 clears the count. At CLKS_PER_BIT consecutive highs go to IDLE. This prevents locking onto mid-frame data after reset or a break.
- IDLE: on rx_s=0, clear the counter and go to START.
- START: count to CLKS_PER_BIT/2-1, then take the vote.
  - Vote 0: clear the counter and the bit index, go to DATA.
  - Vote 1: glitch; go to IDLE with no output.
- DATA: count 0..CLKS_PER_BIT-1. At terminal count (mid-bit), shift the vote into bit 7 of the shift register (shift right, LSB first) and increment the bit index. After the 8th bit go to STOP.
- STOP: count to CLKS_PER_BIT-1, then take the vote.
  - Vote 1: dataByte<=shift register, dataReady=1 for exactly that cycle, go to IDLE.
  - Vote 0: frameErr=1 for one cycle, dataByte unchanged, go to HUNT.

Timing and edge cases:
- Latency: dataReady asserts 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±2) after rxd falls for the start bit. This is mid stop bit, so back-to-back frames with zero idle are received.
- dataReady and frameErr are never high in the same cycle. There is no overrun condition, since the consumer cannot stall.
- A line held low for longer than a frame (break) gives one frameErr, then HUNT until the line is high for 1 bit time.
- The counter never wraps outside the states above; each state clears it on entry.

Test Plan:
All scenarios use SYSCLK_FREQ=100_000_000 and BAUD_RATE=1_000_000, so CLKS_PER_BIT=100.
1. After reset, rxd high for 200 cycles, then send 0x24 ('$') → a single dataReady pulse 952±2 cycles after the start edge; dataByte=0x24; frameErr stays 0.
2. Send "$GPGGA," back-to-back with no idle bits → exactly 7 dataReady pulses, 1000 cycles apart, with bytes 0x24,0x47,0x50,0x47,0x47,0x41,0x2C.
3. A 30-cycle low glitch on idle rxd, then 0x2A ('*') → no output for the glitch; dataByte=0x2A on the frame.
4. Send 0x41 with stop bit forced 0, hold rxd low 500 cycles, release, then send 0x47 → one frameErr pulse; dataByte remains the prior value (0x00 from reset); 0x47 is then received correctly.
5. Assert rstn low during data bit 4 of 0x55 → outputs clear immediately, asynchronously. Release while the remaining bits are still arriving → no dataReady or frameErr for that frame; the next 0x0D is received correctly after 100 high cycles.
6. A single-cycle 1 spike at mid-bit inside data bit 2 of 0x00 → majority vote rejects it; dataByte=0x00 with dataReady asserted.

Source files
------------

// File: rtl/gps_uart_rx_if.sv
// Serial-side and byte-side signals of the GPS UART receiver.
// master: the receiver itself. slave: whatever drives rxd and consumes bytes.
interface gps_uart_rx_if;
  logic       rxd;
  logic [7:0] dataByte;
  logic       dataReady;
  logic       frameErr;

  modport master (
    input  rxd,
    output dataByte,
    output dataReady,
    output frameErr
  );

  modport slave (
    output rxd,
    input  dataByte,
    input  dataReady,
    input  frameErr
  );
endinterface

// File: rtl/gps_uart_rx.sv
// 8N1 LSB-first UART receiver for the GPS link. The line is synchronised, majority-voted over
// the last three synchronised samples, and decoded by a counter-driven FSM. It emits a
// 1-cycle dataReady with the byte, or a 1-cycle frameErr when the stop bit votes low.
// After reset or a framing error the receiver hunts for one full bit time of idle line
// before it accepts a start edge, so it never locks onto the middle of a frame.
module gps_uart_rx #(
  parameter int unsigned SYSCLK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 9600
) (
  input logic           sclk,
  input logic           rstn,
  gps_uart_rx_if.master bus
);

  localparam int unsigned CLKS_PER_BIT = SYSCLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  // Terminal counts: one full bit, and half a bit to land mid start bit.
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  // Below 16 clocks per bit the half-bit and vote windows no longer fit sensibly.
  if (CLKS_PER_BIT < 16) begin : g_bad_cfg
    $error("gps_uart_rx: SYSCLK_FREQ/BAUD_RATE must be at least 16");
  end

  typedef enum logic [2:0] {
    StHunt,
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  logic [1:0]       sync_q;
  logic             rx_s;
  logic [2:0]       hist_q;
  logic             vote;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_byte_q;
  logic             data_ready_q;
  logic             frame_err_q;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.rxd};
    end
  end

  assign rx_s = sync_q[1];

  // History of the three most recent synchronised samples for the majority vote.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      hist_q <= 3'b111;
    end else begin
      hist_q <= {hist_q[1:0], rx_s};
    end
  end

  // 2-of-3 majority; a single-cycle spike cannot flip a sampled bit.
  always_comb begin
    vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  end

  // Receive FSM with registered byte and strobe outputs.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StHunt;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_byte_q  <= '0;
      data_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      data_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;

      unique case (state_q)
        StHunt: begin
          // Require a full bit time of continuous idle before trusting the line.
          if (rx_s) begin
            if (cnt_q == CNT_BIT_END) begin
              cnt_q   <= '0;
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end else begin
            cnt_q <= '0;
          end
        end

        StIdle: begin
          if (!rx_s) begin
            cnt_q   <= '0;
            state_q <= StStart;
          end
        end

        StStart: begin
          if (cnt_q == CNT_HALF_END) begin
            cnt_q <= '0;
            if (!vote) begin
              bit_idx_q <= '0;
              state_q   <= StData;
            end else begin
              // Start edge did not survive to mid-bit: treat as a glitch.
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        StData: begin
          if (cnt_q == CNT_BIT_END) begin
            cnt_q     <= '0;
            shift_q   <= {vote, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        StStop: begin
          // Decision is made mid stop bit, leaving half a bit to catch a back-to-back start.
          if (cnt_q == CNT_BIT_END) begin
            cnt_q <= '0;
            if (vote) begin
              data_byte_q  <= shift_q;
              data_ready_q <= 1'b1;
              state_q      <= StIdle;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= StHunt;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          cnt_q   <= '0;
          state_q <= StHunt;
        end
      endcase
    end
  end

  assign bus.dataByte  = data_byte_q;
  assign bus.dataReady = data_ready_q;
  assign bus.frameErr  = frame_err_q;

endmodule
